test_ostream_checker: RTL and testbench
=======================================

Name: test_ostream_checker

Overview:
Synthesizable stream sink that sits directly downstream of a test input stream or the DUT it drives. It consumes a val/rdy message stream and compares each received message, in order, against a queue of expected messages loaded through a second val/rdy interface. It applies a programmable receive-interval delay, counts received messages and mismatches, and flags errors for the bench.

Parameters:
p_msg_nbits, 32, message width in bits
p_recv_intv_delay, 0, cycles rdy is held low after reset and after each accepted message
p_depth, 16, expected-message queue depth (power of two, >= 2)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
msg  input  p_msg_nbits  received message
val  input  1  received message valid
rdy  output  1  checker ready to accept msg
exp_msg  input  p_msg_nbits  expected message to enqueue
exp_val  input  1  expected message valid
exp_rdy  output  1  expected queue can accept
num_recv  output  16  messages accepted (saturating)
num_err  output  16  mismatches seen (saturating)
err  output  1  one-cycle pulse, registered, on mismatch
err_got  output  p_msg_nbits  msg of most recent mismatch
err_exp  output  p_msg_nbits  expected value of most recent mismatch
idle  output  1  expected queue empty and no error pulse pending

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (port rst). Asserting rst clears the queue, sets num_recv=0, num_err=0, err=0, err_got=0, err_exp=0, and reloads the delay counter to p_recv_intv_delay. While rst is high, rdy=0 and exp_rdy=0.
- Reset mid-operation: all in-flight expectations are discarded. No transfer is counted in the cycle rst is high.
- Expected queue: circular buffer with log2(p_depth)+1-bit read/write pointers, so full and empty are distinct.
  - exp_rdy = !full && !rst.
  - Enqueue on exp_val && exp_rdy at posedge clk.
  - Dequeue and enqueue in the same cycle are both legal when 0 < count < p_depth.
  - Pointers wrap modulo p_depth.
- Delay FSM:
  - States: WAIT, READY.
  - WAIT: counter > 0, decrement each cycle; go to READY on the cycle the counter reaches 0.
  - READY: on a transfer, reload the counter. Stay in READY if p_recv_intv_delay==0, otherwise go to WAIT.
  - After reset, the state is READY if p_recv_intv_delay==0, otherwise WAIT.
- rdy = (state==READY) && !empty && !rst. rdy is combinational from registered state only; it has no combinational path from val.
- Transfer occurs when val && rdy at posedge clk. On a transfer:
  - Pop the head.
  - Increment num_recv, saturating at 16'hFFFF.
  - Compare msg with the head across all p_msg_nbits bits. If unequal: increment num_err (saturating), set err=1 on the next cycle only, and capture err_got=msg and err_exp=head.
  - If equal, err=0 next cycle.
- Back-to-back: with p_recv_intv_delay==0 and the queue non-empty, one message per cycle. With delay N, at most one message per N+1 cycles.
- Empty queue: rdy stays low, so an unexpected message stalls the source and is never accepted. The bench detects this by timeout.
- No bypass: an expectation enqueued in cycle t is first comparable in cycle t+1.
- idle = empty && !err.
- Latency: err, num_recv, and num_err update one cycle after the accepting edge.

Test Plan:
- Delay 0, load 0x11,0x22,0x33, then send the same three back-to-back -> rdy high 3 consecutive cycles, num_recv=3, num_err=0, err never high, idle=1 afterward.
- Load 0xA5, send 0xA4 -> err pulses exactly one cycle, num_err=1, err_got=0xA4, err_exp=0xA5.
- p_recv_intv_delay=2, load and send 4 matching messages with val held high -> accepted at cycles spaced exactly 3 apart, rdy low 2 cycles after reset and after each transfer.
- p_depth=4, enqueue 5 expectations with no receive -> exp_rdy drops after the 4th; the 5th is held until a dequeue. With a simultaneous enqueue and dequeue at count 2, count stays 2.
- val high with empty queue for 10 cycles -> rdy stays 0, num_recv stays 0. Then enqueue 0x7 with msg=0x7 -> accepted the following cycle.
- Assert rst asynchronously (mid-cycle) with 3 queued expectations and num_err=1 -> rdy and exp_rdy fall immediately, and after release the counters and error fields are 0 and idle=1.

Source files
------------

// File: rtl/test_ostream_checker_if.sv
// ---------------------------------------------------------------------------
// test_ostream_checker_if
// Purpose : val/rdy message stream bundle. It is used both for the received
//           message stream and for the expected-message load stream of the
//           output-stream checker.
// Signals : msg [p_msg_nbits] - message payload (driven by master)
//           val               - payload valid   (driven by master)
//           rdy               - sink ready      (driven by slave)
// Modports: master drives msg/val and observes rdy.
//           slave observes msg/val and drives rdy.
// ---------------------------------------------------------------------------
interface test_ostream_checker_if #(
  parameter int p_msg_nbits = 32
);
  logic [p_msg_nbits-1:0] msg;
  logic                   val;
  logic                   rdy;

  modport master (output msg, output val, input rdy);
  modport slave  (input msg, input val, output rdy);
endinterface

// File: rtl/test_ostream_checker.sv
// ---------------------------------------------------------------------------
// test_ostream_checker
// Purpose : stream sink that compares each received message, in order,
//           against a queue of expected messages. After reset and after
//           each accepted message, rdy is held low for p_recv_intv_delay
//           cycles. Accepted messages and mismatches are counted, and the
//           most recent mismatch is captured.
// Ports   : clk          - clock
//           rst          - asynchronous, active-high reset
//           recv         - slave stream of received messages (msg/val/rdy)
//           exp_stream   - slave stream loading expected messages
//           num_recv[16] - accepted messages, saturating
//           num_err[16]  - mismatches, saturating
//           err          - registered one-cycle pulse after a mismatch
//           err_got      - received msg of the most recent mismatch
//           err_exp      - expected msg of the most recent mismatch
//           idle         - expected queue empty and no error pulse pending
// ---------------------------------------------------------------------------
module test_ostream_checker #(
  parameter int p_msg_nbits       = 32,
  parameter int p_recv_intv_delay = 0,
  parameter int p_depth           = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  test_ostream_checker_if.slave  recv,
  test_ostream_checker_if.slave  exp_stream,
  output logic [15:0]            num_recv,
  output logic [15:0]            num_err,
  output logic                   err,
  output logic [p_msg_nbits-1:0] err_got,
  output logic [p_msg_nbits-1:0] err_exp,
  output logic                   idle
);

  localparam int AW = $clog2(p_depth);
  localparam int CW = (p_recv_intv_delay > 0) ? $clog2(p_recv_intv_delay + 1) : 1;
  localparam logic [CW-1:0] DLY = CW'(p_recv_intv_delay);

  typedef enum logic {
    ST_WAIT,
    ST_READY
  } state_t;

  localparam state_t RST_STATE = (p_recv_intv_delay == 0) ? ST_READY : ST_WAIT;

  logic [p_msg_nbits-1:0] mem [p_depth];
  // One extra pointer bit separates the full and empty conditions.
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic                   empty;
  logic                   full;
  logic [p_msg_nbits-1:0] head;

  state_t                 state;
  logic [CW-1:0]          cnt;

  logic                   xfer;
  logic                   enq;
  logic                   mismatch;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Ready depends on registered state only, never on val.
  assign exp_stream.rdy = !full && !rst;
  assign recv.rdy       = (state == ST_READY) && !empty && !rst;

  assign xfer     = recv.val && recv.rdy;
  assign enq      = exp_stream.val && exp_stream.rdy;
  assign mismatch = (recv.msg != head);

  assign idle = empty && !err;

  // Queue storage has no reset; pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr[AW-1:0]] <= exp_stream.msg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      state    <= RST_STATE;
      cnt      <= DLY;
      num_recv <= '0;
      num_err  <= '0;
      err      <= 1'b0;
      err_got  <= '0;
      err_exp  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      case (state)
        ST_WAIT: begin
          // Leave WAIT on the edge where the counter reaches zero.
          if (cnt <= CW'(1)) begin
            cnt   <= '0;
            state <= ST_READY;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_READY: begin
          if (xfer) begin
            cnt   <= DLY;
            state <= (p_recv_intv_delay == 0) ? ST_READY : ST_WAIT;
          end
        end
        default: begin
          state <= RST_STATE;
          cnt   <= DLY;
        end
      endcase

      err <= xfer && mismatch;

      if (xfer) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (num_recv != 16'hFFFF) begin
          num_recv <= num_recv + 16'd1;
        end
        if (mismatch) begin
          if (num_err != 16'hFFFF) begin
            num_err <= num_err + 16'd1;
          end
          err_got <= recv.msg;
          err_exp <= head;
        end
      end
    end
  end

endmodule

// File: tb/tb_test_ostream_checker.sv
module tb_test_ostream_checker;

  localparam int W    = 32;
  localparam int D0   = 0;
  localparam int D1   = 2;
  localparam int DEP0 = 4;
  localparam int DEP1 = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Stimulus, per DUT index (0: delay 0 / depth 4, 1: delay 2 / depth 8)
  logic [W-1:0] s_msg  [2];
  logic         s_val  [2];
  logic [W-1:0] s_exp  [2];
  logic         s_eval [2];

  test_ostream_checker_if #(.p_msg_nbits(W)) rx0 ();
  test_ostream_checker_if #(.p_msg_nbits(W)) ex0 ();
  test_ostream_checker_if #(.p_msg_nbits(W)) rx1 ();
  test_ostream_checker_if #(.p_msg_nbits(W)) ex1 ();

  assign rx0.msg = s_msg[0];
  assign rx0.val = s_val[0];
  assign ex0.msg = s_exp[0];
  assign ex0.val = s_eval[0];
  assign rx1.msg = s_msg[1];
  assign rx1.val = s_val[1];
  assign ex1.msg = s_exp[1];
  assign ex1.val = s_eval[1];

  logic [15:0]  nr0, nr1, ne0, ne1;
  logic         er0, er1, id0, id1;
  logic [W-1:0] eg0, eg1, ee0, ee1;

  test_ostream_checker #(.p_msg_nbits(W), .p_recv_intv_delay(D0), .p_depth(DEP0)) dut0 (
    .clk(clk), .rst(rst), .recv(rx0), .exp_stream(ex0),
    .num_recv(nr0), .num_err(ne0), .err(er0),
    .err_got(eg0), .err_exp(ee0), .idle(id0)
  );

  test_ostream_checker #(.p_msg_nbits(W), .p_recv_intv_delay(D1), .p_depth(DEP1)) dut1 (
    .clk(clk), .rst(rst), .recv(rx1), .exp_stream(ex1),
    .num_recv(nr1), .num_err(ne1), .err(er1),
    .err_got(eg1), .err_exp(ee1), .idle(id1)
  );

  logic         o_rdy  [2];
  logic         o_erdy [2];
  logic         o_err  [2];
  logic         o_idle [2];
  logic [15:0]  o_nr   [2];
  logic [15:0]  o_ne   [2];
  logic [W-1:0] o_eg   [2];
  logic [W-1:0] o_ee   [2];

  assign o_rdy[0]  = rx0.rdy;  assign o_rdy[1]  = rx1.rdy;
  assign o_erdy[0] = ex0.rdy;  assign o_erdy[1] = ex1.rdy;
  assign o_err[0]  = er0;      assign o_err[1]  = er1;
  assign o_idle[0] = id0;      assign o_idle[1] = id1;
  assign o_nr[0]   = nr0;      assign o_nr[1]   = nr1;
  assign o_ne[0]   = ne0;      assign o_ne[1]   = ne1;
  assign o_eg[0]   = eg0;      assign o_eg[1]   = eg1;
  assign o_ee[0]   = ee0;      assign o_ee[1]   = ee1;

  // Reference model: queue of pending expectations, counters, and the
  // earliest edge at which the next message may be accepted.
  logic [W-1:0] mq [2][$];
  int           m_nr [2];
  int           m_ne [2];
  logic         m_err [2];
  logic [W-1:0] m_eg [2];
  logic [W-1:0] m_ee [2];
  int           earliest [2];
  int           cyc;

  logic         x_fl  [2];
  logic         x_enq [2];
  int           acc_edge [2];
  int           enq_edge [2];
  int           acc_q [2][$];
  logic [W-1:0] pend_exp [2][$];
  logic [W-1:0] pend_msg [2][$];

  int n_chk = 0;
  int n_err = 0;

  function automatic int dly_of(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  function automatic int dep_of(input int i);
    return (i == 0) ? DEP0 : DEP1;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_nr[i]     = 0;
      m_ne[i]     = 0;
      m_err[i]    = 1'b0;
      m_eg[i]     = '0;
      m_ee[i]     = '0;
      earliest[i] = dly_of(i) + 1;
      x_fl[i]     = 1'b0;
      x_enq[i]    = 1'b0;
    end
    cyc = 1;
  endtask

  // One clock: check ready outputs before the edge, advance the model at
  // the edge, check registered outputs 1 time unit after it.
  task automatic tick();
    logic         pr [2];
    logic         pe [2];
    logic [W-1:0] h;
    for (int i = 0; i < 2; i++) begin
      pr[i] = (cyc >= earliest[i]) && (mq[i].size() > 0);
      pe[i] = (mq[i].size() < dep_of(i));
      check($sformatf("rdy%0d", i), W'(o_rdy[i]), W'(pr[i]));
      check($sformatf("exp_rdy%0d", i), W'(o_erdy[i]), W'(pe[i]));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      x_fl[i]  = s_val[i] && pr[i];
      x_enq[i] = s_eval[i] && pe[i];
      m_err[i] = 1'b0;
      if (x_fl[i]) begin
        h = mq[i].pop_front();
        if (m_nr[i] < 65535) m_nr[i]++;
        if (s_msg[i] !== h) begin
          if (m_ne[i] < 65535) m_ne[i]++;
          m_err[i] = 1'b1;
          m_eg[i]  = s_msg[i];
          m_ee[i]  = h;
        end
        earliest[i] = cyc + dly_of(i) + 1;
        acc_edge[i] = cyc;
      end
      if (x_enq[i]) begin
        mq[i].push_back(s_exp[i]);
        enq_edge[i] = cyc;
      end
    end
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("err%0d", i), W'(o_err[i]), W'(m_err[i]));
      check($sformatf("num_recv%0d", i), W'(o_nr[i]), W'(m_nr[i]));
      check($sformatf("num_err%0d", i), W'(o_ne[i]), W'(m_ne[i]));
      check($sformatf("err_got%0d", i), o_eg[i], m_eg[i]);
      check($sformatf("err_exp%0d", i), o_ee[i], m_ee[i]);
      check($sformatf("idle%0d", i), W'(o_idle[i]), W'((mq[i].size() == 0) && !m_err[i]));
    end
  endtask

  // Feed pending expectations and messages into DUT i until both lists are
  // drained or the cycle budget expires.
  task automatic run(input int i, input int budget, input bit must_finish, input int gap_pct);
    int n = 0;
    while ((pend_exp[i].size() > 0 || pend_msg[i].size() > 0) && n < budget) begin
      s_eval[i] = 1'b0;
      s_val[i]  = 1'b0;
      if (pend_exp[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
        s_eval[i] = 1'b1;
        s_exp[i]  = pend_exp[i][0];
      end
      if (pend_msg[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
        s_val[i] = 1'b1;
        s_msg[i] = pend_msg[i][0];
      end
      tick();
      if (x_enq[i]) void'(pend_exp[i].pop_front());
      if (x_fl[i]) begin
        void'(pend_msg[i].pop_front());
        acc_q[i].push_back(acc_edge[i]);
      end
      n++;
    end
    s_eval[i] = 1'b0;
    s_val[i]  = 1'b0;
    if (must_finish)
      check($sformatf("timeout%0d", i), W'(pend_exp[i].size() + pend_msg[i].size()), W'(0));
  endtask

  // Asynchronous reset asserted mid-cycle, released away from an edge.
  task automatic do_reset();
    #3;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_val[i]  = 1'b0;
      s_eval[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_rdy%0d", i), W'(o_rdy[i]), W'(0));
      check($sformatf("rst_exp_rdy%0d", i), W'(o_erdy[i]), W'(0));
    end
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rel_num_recv%0d", i), W'(o_nr[i]), W'(0));
      check($sformatf("rel_num_err%0d", i), W'(o_ne[i]), W'(0));
      check($sformatf("rel_err%0d", i), W'(o_err[i]), W'(0));
      check($sformatf("rel_err_got%0d", i), o_eg[i], W'(0));
      check($sformatf("rel_err_exp%0d", i), o_ee[i], W'(0));
      check($sformatf("rel_idle%0d", i), W'(o_idle[i]), W'(1));
    end
  endtask

  initial begin
    logic [W-1:0] v [6];
    logic [W-1:0] rv;
    int           n;
    int           di;

    for (int i = 0; i < 2; i++) begin
      s_msg[i] = '0; s_val[i] = 1'b0; s_exp[i] = '0; s_eval[i] = 1'b0;
    end
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Delay 2: four matching messages with val held high from reset.
    for (int k = 0; k < 4; k++) begin
      pend_exp[1].push_back(32'h100 + k);
      pend_msg[1].push_back(32'h100 + k);
    end
    acc_q[1].delete();
    run(1, 40, 1'b1, 0);
    check("d2_count", W'(acc_q[1].size()), W'(4));
    for (int k = 0; k < acc_q[1].size(); k++)
      check($sformatf("d2_edge%0d", k), W'(acc_q[1][k]), W'(3 * (k + 1)));

    // Delay 0: load three, then send three back-to-back.
    pend_exp[0].push_back(32'h11);
    pend_exp[0].push_back(32'h22);
    pend_exp[0].push_back(32'h33);
    run(0, 10, 1'b1, 0);
    pend_msg[0].push_back(32'h11);
    pend_msg[0].push_back(32'h22);
    pend_msg[0].push_back(32'h33);
    acc_q[0].delete();
    run(0, 10, 1'b1, 0);
    check("b2b_count", W'(acc_q[0].size()), W'(3));
    if (acc_q[0].size() == 3) begin
      check("b2b_gap1", W'(acc_q[0][1] - acc_q[0][0]), W'(1));
      check("b2b_gap2", W'(acc_q[0][2] - acc_q[0][1]), W'(1));
    end
    check("b2b_num_recv", W'(o_nr[0]), W'(3));
    check("b2b_num_err", W'(o_ne[0]), W'(0));
    check("b2b_idle", W'(o_idle[0]), W'(1));

    // Mismatch: expect 0xA5, receive 0xA4.
    pend_exp[0].push_back(32'hA5);
    pend_msg[0].push_back(32'hA4);
    run(0, 10, 1'b1, 0);
    check("mm_err_high", W'(o_err[0]), W'(1));
    check("mm_num_err", W'(o_ne[0]), W'(1));
    check("mm_err_got", o_eg[0], 32'hA4);
    check("mm_err_exp", o_ee[0], 32'hA5);
    tick();
    check("mm_err_low", W'(o_err[0]), W'(0));

    // Depth 4: fill, block the fifth, then overlap enqueue/dequeue at count 2.
    do_reset();
    for (int k = 0; k < 6; k++) v[k] = 32'hC0 + k;
    for (int k = 0; k < 5; k++) pend_exp[0].push_back(v[k]);
    run(0, 6, 1'b0, 0);
    check("full_held", W'(pend_exp[0].size()), W'(1));
    check("full_exp_rdy", W'(o_erdy[0]), W'(0));
    pend_msg[0].push_back(v[0]);
    run(0, 10, 1'b1, 0);
    pend_msg[0].push_back(v[1]);
    pend_msg[0].push_back(v[2]);
    run(0, 10, 1'b1, 0);
    pend_exp[0].push_back(v[5]);
    pend_msg[0].push_back(v[3]);
    run(0, 4, 1'b1, 0);
    pend_msg[0].push_back(v[4]);
    pend_msg[0].push_back(v[5]);
    run(0, 10, 1'b1, 0);
    check("full_num_recv", W'(o_nr[0]), W'(6));
    check("full_num_err", W'(o_ne[0]), W'(0));
    check("full_idle", W'(o_idle[0]), W'(1));

    // Empty queue stalls the source; a later expectation releases it.
    do_reset();
    pend_msg[0].push_back(32'h7);
    run(0, 10, 1'b0, 0);
    check("stall_held", W'(pend_msg[0].size()), W'(1));
    check("stall_num_recv", W'(o_nr[0]), W'(0));
    pend_exp[0].push_back(32'h7);
    run(0, 10, 1'b1, 0);
    check("stall_latency", W'(acc_edge[0] - enq_edge[0]), W'(1));
    check("stall_num_recv2", W'(o_nr[0]), W'(1));

    // Reset with three queued expectations and one recorded mismatch.
    for (int k = 1; k <= 4; k++) pend_exp[0].push_back(W'(k));
    pend_msg[0].push_back(32'h9);
    run(0, 10, 1'b1, 0);
    check("pre_rst_num_err", W'(o_ne[0]), W'(1));
    check("pre_rst_rdy", W'(o_rdy[0]), W'(1));
    do_reset();

    // Randomized traffic with occasional corrupted messages and gaps.
    for (int r = 0; r < 6; r++) begin
      di = r % 2;
      n  = $urandom_range(20, 5);
      for (int k = 0; k < n; k++) begin
        rv = $urandom;
        pend_exp[di].push_back(rv);
        if ($urandom_range(3) == 0) rv = rv ^ (W'(1) << $urandom_range(W - 1));
        pend_msg[di].push_back(rv);
      end
      run(di, 400, 1'b1, 30);
    end
    for (int k = 0; k < 4; k++) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
